// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types: PCSrc encoding, fetch FSM states and the
// {instr, pc} entry carried by the fetch buffers.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10
    } pc_src_t;

    typedef enum logic [1:0] {
        ST_RST_WAIT = 2'b00,
        ST_FETCH    = 2'b01,
        ST_HALT     = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side handshakes of the fetch stage.
// The master modport is the fetch unit; slave is the memory/decode side.
interface fetch_unit_if;
    import rv32_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            instr_valid;
    logic            dec_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [1:0]      pc_src;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] alu_result;
    logic            misalign;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, pc, pc_plus4, misalign,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
               pc_src, imm_ext, alu_result
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, pc, pc_plus4, misalign,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
               pc_src, imm_ext, alu_result
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc} entries with push/pop/flush and occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push_s;
    logic           do_pop_s;

    // Qualify push/pop against occupancy and compute next pointers/count.
    always_comb begin
        do_pop_s  = pop_i && (count_q != '0);
        do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed behind a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers
// responses and applies PCSrc redirects from decode, discarding stale responses.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_unit_if.master     bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    fetch_entry_t    fifo_head_s, fifo_push_data_s;
    fetch_entry_t    pcq_head_s, pcq_push_data_s;
    logic [CW-1:0]   fifo_count_s, pcq_count_s;
    logic            fifo_empty_s, pcq_empty_s;
    logic [CW:0]     inflight_s;
    logic [CW-1:0]   outstanding_nxt_s;

    logic            req_valid_s, req_fire_s;
    logic            rsp_fire_s, rsp_drop_s, fifo_push_s;
    logic            instr_valid_s, pop_s, misalign_s;
    logic            redirect_s, misaligned_s;
    logic [XLEN-1:0] target_s;

    // Buffered instructions presented to decode.
    fetch_fifo #(.DEPTH(DEPTH)) u_instr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push_s),
        .push_data_i (fifo_push_data_s),
        .pop_i       (pop_s),
        .flush_i     (redirect_s),
        .head_o      (fifo_head_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s)
    );

    // Addresses of requests still in memory; its occupancy is the outstanding
    // count, so it is never flushed (dropped responses still retire an entry).
    fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (req_fire_s),
        .push_data_i (pcq_push_data_s),
        .pop_i       (rsp_fire_s),
        .flush_i     (1'b0),
        .head_o      (pcq_head_s),
        .count_o     (pcq_count_s),
        .empty_o     (pcq_empty_s)
    );

    assign inflight_s = {1'b0, pcq_count_s} + {1'b0, fifo_count_s};

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: HALT is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST_WAIT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (misaligned_s) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_RST_WAIT;
        endcase
    end

    // FSM outputs: issue only while the request budget has room.
    always_comb begin
        req_valid_s   = 1'b0;
        instr_valid_s = 1'b0;
        misalign_s    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                req_valid_s   = (inflight_s < (CW+1)'(DEPTH));
                instr_valid_s = !fifo_empty_s;
            end
            ST_HALT: begin
                misalign_s = 1'b1;
            end
            default: begin
                req_valid_s   = 1'b0;
                instr_valid_s = 1'b0;
                misalign_s    = 1'b0;
            end
        endcase
    end

    // Handshakes, redirect target and response routing.
    always_comb begin
        req_fire_s = req_valid_s && bus.imem_req_ready;
        rsp_fire_s = bus.imem_rsp_valid && !pcq_empty_s;
        rsp_drop_s = rsp_fire_s && (drop_cnt_q != '0);
        pop_s      = instr_valid_s && bus.dec_ready;
        redirect_s = 1'b0;
        target_s   = '0;
        case (pc_src_t'(bus.pc_src))
            PC_BRANCH: begin
                redirect_s = pop_s;
                target_s   = fifo_head_s.pc + bus.imm_ext;
            end
            PC_JALR: begin
                redirect_s = pop_s;
                target_s   = bus.alu_result & ~32'h0000_0001;
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = '0;
            end
        endcase
        misaligned_s = redirect_s && is_misaligned(target_s);
        // A redirect discards even a response that was not already marked stale.
        fifo_push_s  = rsp_fire_s && !rsp_drop_s && !redirect_s && (state_q == ST_FETCH);

        pcq_push_data_s       = '0;
        pcq_push_data_s.pc    = fetch_pc_q;
        fifo_push_data_s       = pcq_head_s;
        fifo_push_data_s.instr = bus.imem_rsp_data;

        outstanding_nxt_s = pcq_count_s + CW'(req_fire_s) - CW'(rsp_fire_s);
    end

    // Next fetch PC and stale-response count.
    always_comb begin
        if (redirect_s) begin
            fetch_pc_d = target_s;
            drop_cnt_d = outstanding_nxt_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_drop_s) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Fetch PC and drop counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_addr      = req_valid_s   ? fetch_pc_q                 : '0;
    assign bus.instr_valid    = instr_valid_s;
    assign bus.instr          = instr_valid_s ? fifo_head_s.instr          : '0;
    assign bus.pc             = instr_valid_s ? fifo_head_s.pc             : '0;
    assign bus.pc_plus4       = instr_valid_s ? fifo_head_s.pc + 32'd4     : '0;
    assign bus.misalign       = misalign_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a memory model answers every request with
// addr^FFFFFFFF and a program-order reference predicts each delivered instruction.
module tb_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        halts;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc = 0;
    int          lat = 1;
    int          rdy_pct = 100;
    int          dec_pct = 100;
    int          br_pct = 0;
    int          delivered = 0;
    int          first_valid = -1;
    logic [31:0] ref_pc = RST_PC;
    logic [31:0] first_req = 32'd0;
    bit          first_req_seen = 1'b0;
    bit          halted_m = 1'b0;
    bit          dir_en = 1'b0;
    logic [31:0] dir_pc = 32'd0;
    logic [1:0]  dir_src = 2'b00;
    logic [31:0] dir_val = 32'd0;
    bit          cur_redir = 1'b0;
    bit          cur_mis = 1'b0;
    logic [31:0] cur_tgt = 32'd0;
    bit          pend_tgt = 1'b0;
    logic [31:0] tgt_exp = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Present memory response and decode inputs for the cycle just started.
    task automatic drive_cycle();
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] tgt;
        bit          redir;
        int          k;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        if (mem_q.size() > 0) begin
            if (mem_q[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_q[0].addr ^ 32'hFFFF_FFFF;
            end
        end
        bus.imem_req_ready = ($urandom_range(99) < 32'(rdy_pct));
        bus.dec_ready      = ($urandom_range(99) < 32'(dec_pct));
        src = 2'b00;
        imm = $urandom();
        alu = $urandom();
        cur_redir = 1'b0;
        cur_mis   = 1'b0;
        cur_tgt   = 32'd0;
        if (bus.instr_valid && bus.dec_ready) begin
            if (dir_en && (ref_pc == dir_pc)) begin
                src    = dir_src;
                imm    = dir_val;
                alu    = dir_val;
                dir_en = 1'b0;
            end else if ($urandom_range(99) < 32'(br_pct)) begin
                src = 2'($urandom_range(3, 1));
                k   = int'($urandom_range(32)) - 16;
                imm = 32'(k * 4);
                alu = (RST_PC + ($urandom() & 32'h0000_0FFC)) | ($urandom() & 32'h1);
            end
            redir = (src == 2'b01) || (src == 2'b10);
            tgt   = (src == 2'b01) ? (ref_pc + imm) : (alu & 32'hFFFF_FFFE);
            exp_q.push_back('{pc: ref_pc, halts: redir && (tgt[1:0] != 2'b00)});
            if (redir) begin
                cur_redir = 1'b1;
                cur_mis   = (tgt[1:0] != 2'b00);
                cur_tgt   = tgt;
                ref_pc    = tgt;
            end else begin
                ref_pc = ref_pc + 32'd4;
            end
        end
        bus.pc_src     = src;
        bus.imm_ext    = imm;
        bus.alu_result = alu;
    endtask

    // One clock: observe handshakes at the falling edge, advance memory after the rise.
    task automatic step();
        bit          req_hs;
        bit          rsp_now;
        logic [31:0] addr;
        @(negedge clk);
        req_hs  = bus.imem_req_valid && bus.imem_req_ready;
        rsp_now = bus.imem_rsp_valid;
        addr    = bus.imem_addr;
        if (req_hs) begin
            chk("addr_align", {30'd0, addr[1:0]}, 32'd0);
            if (!first_req_seen) begin
                first_req_seen = 1'b1;
                first_req      = addr;
            end
            if (pend_tgt) begin
                chk("redirect_addr", addr, tgt_exp);
                pend_tgt = 1'b0;
            end
        end
        if (cur_redir) begin
            pend_tgt = !cur_mis;
            tgt_exp  = cur_tgt;
        end
        if (bus.instr_valid && (first_valid < 0)) begin
            first_valid = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (req_hs) begin
            mem_q.push_back('{addr: addr, due: cyc + lat - 1});
        end
        if (rsp_now && (mem_q.size() > 0)) begin
            void'(mem_q.pop_front());
        end
        drive_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    // Assert reset mid-cycle, check the quiet outputs, release after a rising edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_pc_plus4", bus.pc_plus4, 32'd0);
        chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
        mem_q.delete();
        exp_q.delete();
        ref_pc         = RST_PC;
        halted_m       = 1'b0;
        pend_tgt       = 1'b0;
        cur_redir      = 1'b0;
        cur_mis        = 1'b0;
        dir_en         = 1'b0;
        first_valid    = -1;
        first_req_seen = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.imem_req_ready = 1'b0;
        bus.dec_ready      = 1'b0;
        bus.pc_src         = 2'b00;
        bus.imm_ext        = 32'd0;
        bus.alu_result     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        chk("rst_wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        drive_cycle();
    endtask

    // Scoreboard monitor: compares every decode handshake against the reference.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (halted_m) begin
                    chk("halt_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
                    chk("halt_misalign", {31'd0, bus.misalign}, 32'd1);
                    chk("halt_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
                end else begin
                    chk("misalign_low", {31'd0, bus.misalign}, 32'd0);
                    if (bus.instr_valid && bus.dec_ready) begin
                        if (exp_q.size() == 0) begin
                            n_total++;
                            $display("FAIL unexpected_pop: actual pc=%h required=no instruction", bus.pc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("pc", bus.pc, e.pc);
                            chk("instr", bus.instr, e.pc ^ 32'hFFFF_FFFF);
                            chk("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
                            delivered++;
                            if (e.halts) begin
                                halted_m = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int d0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.imem_req_ready = 1'b0;
        bus.dec_ready      = 1'b0;
        bus.pc_src         = 2'b00;
        bus.imm_ext        = 32'd0;
        bus.alu_result     = 32'd0;

        // Streaming with a 1-cycle memory and no redirects.
        lat = 1; rdy_pct = 100; dec_pct = 100; br_pct = 0;
        do_reset();
        run(20);
        chk("first_valid_cycle", 32'(first_valid), 32'd3);
        chk("first_req_addr", first_req, RST_PC);
        chk("stream_progress", {31'd0, delivered >= 8}, 32'd1);

        // Decode stall: issue must stop once the budget is used.
        dec_pct = 0;
        run(5);
        chk("stall_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        d0 = delivered;
        dec_pct = 100;
        run(12);
        chk("stall_resume", {31'd0, delivered > d0}, 32'd1);

        // Backward branch from BFC00008.
        do_reset();
        dir_en = 1'b1; dir_pc = RST_PC + 32'd8; dir_src = 2'b01; dir_val = 32'hFFFF_FFF8;
        d0 = delivered;
        run(25);
        chk("branch_taken", {31'd0, dir_en}, 32'd0);
        chk("branch_progress", {31'd0, delivered >= d0 + 8}, 32'd1);

        // JALR to a misaligned target halts the stage.
        do_reset();
        dir_en = 1'b1; dir_pc = RST_PC + 32'd8; dir_src = 2'b10; dir_val = 32'h0000_1003;
        run(15);
        chk("jalr_mis_taken", {31'd0, dir_en}, 32'd0);
        chk("jalr_mis_flag", {31'd0, bus.misalign}, 32'd1);
        chk("jalr_mis_model", {31'd0, halted_m}, 32'd1);

        // JALR clears bit 0 of the target and continues.
        do_reset();
        dir_en = 1'b1; dir_pc = RST_PC + 32'd8; dir_src = 2'b10; dir_val = 32'h0000_1001;
        d0 = delivered;
        run(20);
        chk("jalr_taken", {31'd0, dir_en}, 32'd0);
        chk("jalr_no_halt", {31'd0, bus.misalign}, 32'd0);
        chk("jalr_progress", {31'd0, delivered >= d0 + 6}, 32'd1);

        // Random redirects against slower memories and random backpressure.
        do_reset();
        lat = 3; rdy_pct = 70; dec_pct = 80; br_pct = 15;
        d0 = delivered;
        run(600);
        chk("lat3_progress", {31'd0, delivered > d0 + 50}, 32'd1);

        do_reset();
        lat = 2; rdy_pct = 50; dec_pct = 50; br_pct = 25;
        d0 = delivered;
        run(400);
        chk("lat2_progress", {31'd0, delivered > d0 + 30}, 32'd1);

        // Reset with the buffer full, then restart from the reset PC.
        do_reset();
        lat = 1; rdy_pct = 100; dec_pct = 0; br_pct = 0;
        run(8);
        chk("prefill_valid", {31'd0, bus.instr_valid}, 32'd1);
        do_reset();
        dec_pct = 100;
        d0 = delivered;
        run(20);
        chk("restart_req_addr", first_req, RST_PC);
        chk("restart_progress", {31'd0, delivered >= d0 + 5}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
